// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port byte SRAM between instruction fetch and the
//   load/store unit. Fetch always reads a word. The load/store unit reads
//   or writes a byte or a word. A word access takes two byte cycles: the
//   low byte at A, then the high byte at A+1, with the address wrapping.
//   Read data is returned as an assembled word.
//
//   Build option: define MEM_ARB_RR_EN for round-robin arbitration when both
//   ports request together. Without it the data port always wins.
//
// Ports
//   clk, rst            clock (rising edge); async active-high reset
//   f_req/f_addr        fetch request and byte address, held until f_ack
//   f_flush             abandons the in-flight fetch (no f_ack)
//   f_rdata/f_ack       fetched word {mem[A+1],mem[A]}; 1-cycle ack pulse
//   d_req/d_we/d_size   data request, 1=write, 0=byte/1=word
//   d_addr/d_wdata      data byte address and write data
//   d_rdata/d_ack       read data (byte reads zero-extended); 1-cycle ack
//   mem_en/mem_we       SRAM enable and write enable (registered)
//   mem_addr/mem_wdata  SRAM byte address and write byte (registered)
//   mem_rdata           SRAM read byte, valid the cycle after a read enable
//   busy                transaction in progress
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                f_req,
  input  logic [ADDR_W-1:0]   f_addr,
  input  logic                f_flush,
  output logic [2*BYTE_W-1:0] f_rdata,
  output logic                f_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic                d_size,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2*BYTE_W-1:0] d_wdata,
  output logic [2*BYTE_W-1:0] d_rdata,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BYTE_W-1:0]   mem_wdata,
  input  logic [BYTE_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned WORD_W = 2 * BYTE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_d;

  // Command latched when the winner is granted
  logic              sel_data_q, sel_data_d;
  logic              we_q, we_d;
  logic              word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic              flushed_q, flushed_d;

  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [BYTE_W-1:0] mem_wdata_d;

  logic [WORD_W-1:0] f_rdata_q, f_rdata_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;
  logic [WORD_W-1:0] rd_word;

  // A flush in the same cycle cancels the fetch request
  logic f_live;
  logic grant_data;
  assign f_live = f_req && !f_flush;

`ifdef MEM_ARB_RR_EN
  // last_grant: 0 = fetch, 1 = data; on contention the other port wins
  logic last_grant_q;
  assign grant_data = d_req && (!f_live || !last_grant_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b0;
    end else if (state == IDLE && (d_req || f_live)) begin
      last_grant_q <= grant_data;
    end
  end
`else
  assign grant_data = d_req;
`endif

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_data_q <= 1'b0;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      lo_q       <= '0;
      flushed_q  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state      <= state_d;
      sel_data_q <= sel_data_d;
      we_q       <= we_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_hi_q <= wdata_hi_d;
      lo_q       <= lo_d;
      flushed_q  <= flushed_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      f_rdata_q  <= f_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Next state, latched command and next SRAM command
  always_comb begin
    state_d     = state;
    sel_data_d  = sel_data_q;
    we_d        = we_q;
    word_d      = word_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    lo_d        = lo_q;
    flushed_d   = flushed_q;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    f_rdata_d   = f_ack ? f_rdata : f_rdata_q;
    d_rdata_d   = d_ack ? d_rdata : d_rdata_q;

    case (state)
      IDLE: begin
        flushed_d = 1'b0;
        mem_en_d  = 1'b0;
        mem_we_d  = 1'b0;
        if (grant_data) begin
          state_d     = LO;
          sel_data_d  = 1'b1;
          we_d        = d_we;
          word_d      = d_size;
          addr_d      = d_addr;
          wdata_hi_d  = d_wdata[WORD_W-1:BYTE_W];
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata[BYTE_W-1:0];
        end else if (f_live) begin
          state_d     = LO;
          sel_data_d  = 1'b0;
          we_d        = 1'b0;
          word_d      = 1'b1;
          addr_d      = f_addr;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = f_addr;
        end
      end
      LO: begin
        if (word_q) begin
          state_d     = HI;
          mem_addr_d  = addr_q + ADDR_W'(1);
          mem_wdata_d = wdata_hi_q;
        end else begin
          state_d  = DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      HI: begin
        // Low read byte arrives this cycle
        state_d  = DONE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        lo_d     = mem_rdata;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Remember a flush seen at any point of an in-flight fetch
    if (state != IDLE && !sel_data_q && f_flush) begin
      flushed_d = 1'b1;
    end
  end

  // Acks, returned data and busy
  always_comb begin
    f_ack   = 1'b0;
    d_ack   = 1'b0;
    f_rdata = f_rdata_q;
    d_rdata = d_rdata_q;
    busy    = (state != IDLE);
    rd_word = word_q ? {mem_rdata, lo_q} : WORD_W'(mem_rdata);
    if (state == DONE) begin
      if (sel_data_q) begin
        d_ack = 1'b1;
        if (!we_q) begin
          d_rdata = rd_word;
        end
      end else if (!flushed_q && !f_flush) begin
        f_ack   = 1'b1;
        f_rdata = rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, f_flush = 1'b0, f_ack;
  logic [15:0] f_addr = '0, f_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_size = 1'b0, d_ack;
  logic [15:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(16), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_rdata(f_rdata), .f_ack(f_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM model with a preload port driven by the bench
  logic [7:0]  mem [0:65535] = '{default: 8'h00};
  logic [7:0]  ref_mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  int          we_pulses = 0;
  int          f_acks = 0;
  int          d_acks = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (mem_en && mem_we) we_pulses <= we_pulses + 1;
    if (f_ack) f_acks <= f_acks + 1;
    if (d_ack) d_acks <= d_acks + 1;
  end

  logic [15:0] f_exp_q[$];
  logic [15:0] d_exp_q[$];
  int total = 0;
  int bad = 0;
  logic [15:0] exp_v;
  logic [15:0] last_d;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    ref_mem[a] = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Drives one data request, pushes the expected read word, waits for d_ack
  task automatic data_op(input logic we, input logic size, input logic [15:0] a,
                         input logic [15:0] wd, output int cyc, output logic [15:0] got);
    logic [15:0] a1;
    a1 = a + 16'd1;
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_size = size; d_addr = a; d_wdata = wd;
    if (we) begin
      ref_mem[a] = wd[7:0];
      if (size) ref_mem[a1] = wd[15:8];
    end else begin
      d_exp_q.push_back(size ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]});
    end
    cyc = 0;
    got = 'x;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (d_ack === 1'b1) begin cyc = c; got = d_rdata; break; end
    end
    d_req = 1'b0;
  endtask

  task automatic fetch_op(input logic [15:0] a, output int cyc, output logic [15:0] got);
    logic [15:0] a1;
    a1 = a + 16'd1;
    @(negedge clk);
    f_req = 1'b1; f_addr = a;
    f_exp_q.push_back({ref_mem[a1], ref_mem[a]});
    cyc = 0;
    got = 'x;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (f_ack === 1'b1) begin cyc = c; got = f_rdata; break; end
    end
    f_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({mem_en, mem_we, f_ack, d_ack, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000", {mem_en, mem_we, f_ack, d_ack, busy});
    end
    total++;
    if ({mem_addr, mem_wdata, f_rdata, d_rdata} !== 56'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, f_rdata, d_rdata});
    end
    rst = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_fetch();
    f_exp_q.delete();
    preload(16'h0010, 8'h34);
    preload(16'h0011, 8'h12);
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0010;
    f_exp_q.push_back({ref_mem[16'h0011], ref_mem[16'h0010]});
    step();
    total++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      bad++; $display("FAIL fetch_lo en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr);
    end
    step();
    total++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0011}) begin
      bad++; $display("FAIL fetch_hi en=%b we=%b addr=%h want 1 0 0011", mem_en, mem_we, mem_addr);
    end
    step();
    total++;
    if (f_ack !== 1'b1) begin
      bad++; $display("FAIL fetch_ack_n3 got=%b want=1", f_ack);
    end else begin
      exp_v = f_exp_q.pop_front();
      total++;
      if (f_rdata !== exp_v) begin bad++; $display("FAIL fetch_data got=%h want=%h", f_rdata, exp_v); end
    end
    f_req = 1'b0;
    step();
    total++;
    if ({f_ack, busy, mem_en, f_rdata} !== {3'b000, 16'h1234}) begin
      bad++; $display("FAIL fetch_after ack=%b busy=%b en=%b rdata=%h want 0 0 0 1234", f_ack, busy, mem_en, f_rdata);
    end
  endtask

  task automatic test_contention();
    int fa, da;
    f_exp_q.delete(); d_exp_q.delete();
    preload(16'h0200, 8'hCD);
    preload(16'h0201, 8'hAB);
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = 16'h0200;
    f_exp_q.push_back({ref_mem[16'h0011], ref_mem[16'h0010]});
    d_exp_q.push_back({ref_mem[16'h0201], ref_mem[16'h0200]});
    fa = 0; da = 0;
    for (int c = 1; c <= 12 && (fa == 0 || da == 0); c++) begin
      step();
      if (d_ack === 1'b1) begin
        da = c; d_req = 1'b0;
        exp_v = (d_exp_q.size() != 0) ? d_exp_q.pop_front() : 16'hxxxx;
        total++;
        if (d_rdata !== exp_v) begin bad++; $display("FAIL cont_d_data got=%h want=%h", d_rdata, exp_v); end
        else last_d = exp_v;
      end
      if (f_ack === 1'b1) begin
        fa = c; f_req = 1'b0;
        exp_v = (f_exp_q.size() != 0) ? f_exp_q.pop_front() : 16'hxxxx;
        total++;
        if (f_rdata !== exp_v) begin bad++; $display("FAIL cont_f_data got=%h want=%h", f_rdata, exp_v); end
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    total++;
    if (da != 3) begin bad++; $display("FAIL cont_d_cycle got=%0d want=3", da); end
    total++;
    if (fa != 7) begin bad++; $display("FAIL cont_f_cycle got=%0d want=7", fa); end
  endtask

  // Data re-requests right after its ack while fetch is still waiting
  task automatic test_back_to_back();
    int fa, da1, da2, nd;
    f_exp_q.delete(); d_exp_q.delete();
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0010;
    d_req = 1'b1; d_we = 1'b0; d_size = 1'b1; d_addr = 16'h0200;
    f_exp_q.push_back({ref_mem[16'h0011], ref_mem[16'h0010]});
    d_exp_q.push_back({ref_mem[16'h0201], ref_mem[16'h0200]});
    fa = 0; da1 = 0; da2 = 0; nd = 0;
    for (int c = 1; c <= 16 && (fa == 0 || da2 == 0); c++) begin
      step();
      if (d_ack === 1'b1) begin
        nd++;
        exp_v = (d_exp_q.size() != 0) ? d_exp_q.pop_front() : 16'hxxxx;
        total++;
        if (d_rdata !== exp_v) begin bad++; $display("FAIL b2b_d_data got=%h want=%h", d_rdata, exp_v); end
        else last_d = exp_v;
        if (nd == 1) begin
          da1 = c;
          d_size = 1'b0; d_addr = 16'h0010;
          d_exp_q.push_back({8'h00, ref_mem[16'h0010]});
        end else begin
          da2 = c; d_req = 1'b0;
        end
      end
      if (f_ack === 1'b1) begin
        fa = c; f_req = 1'b0;
        exp_v = (f_exp_q.size() != 0) ? f_exp_q.pop_front() : 16'hxxxx;
        total++;
        if (f_rdata !== exp_v) begin bad++; $display("FAIL b2b_f_data got=%h want=%h", f_rdata, exp_v); end
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    total++;
    if ({da1, da2, fa} != (RR ? {32'd3, 32'd10, 32'd7} : {32'd3, 32'd6, 32'd10})) begin
      bad++; $display("FAIL b2b_order d1=%0d d2=%0d f=%0d want %0d %0d %0d", da1, da2, fa,
                      3, RR ? 10 : 6, RR ? 7 : 10);
    end
  endtask

  task automatic test_byte_write();
    int wp0;
    logic [15:0] hold;
    preload(16'h0006, 8'h77);
    hold = last_d;
    wp0 = we_pulses;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 1'b0; d_addr = 16'h0005; d_wdata = 16'h00AB;
    ref_mem[16'h0005] = 8'hAB;
    step();
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0005, 8'hAB}) begin
      bad++; $display("FAIL bw_lo en=%b we=%b addr=%h wd=%h want 1 1 0005 ab", mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    total++;
    if ({d_ack, mem_en, mem_we} !== 3'b100) begin
      bad++; $display("FAIL bw_ack_n2 ack=%b en=%b we=%b want 1 0 0", d_ack, mem_en, mem_we);
    end
    total++;
    if (d_rdata !== hold) begin bad++; $display("FAIL bw_rdata_hold got=%h want=%h", d_rdata, hold); end
    d_req = 1'b0;
    step();
    total++;
    if (we_pulses - wp0 != 1) begin bad++; $display("FAIL bw_we_pulses got=%0d want=1", we_pulses - wp0); end
    total++;
    if ({mem[16'h0005], mem[16'h0006]} !== {ref_mem[16'h0005], ref_mem[16'h0006]}) begin
      bad++; $display("FAIL bw_mem got=%h %h want=%h %h", mem[16'h0005], mem[16'h0006],
                      ref_mem[16'h0005], ref_mem[16'h0006]);
    end
  endtask

  task automatic test_word_wrap();
    int cyc;
    logic [15:0] got;
    d_exp_q.delete();
    data_op(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, cyc, got);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL ww_write_cycle got=%0d want=3", cyc); end
    step();
    total++;
    if ({mem[16'hFFFF], mem[16'h0000]} !== {ref_mem[16'hFFFF], ref_mem[16'h0000]}) begin
      bad++; $display("FAIL ww_mem got=%h %h want=%h %h", mem[16'hFFFF], mem[16'h0000],
                      ref_mem[16'hFFFF], ref_mem[16'h0000]);
    end
    data_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, cyc, got);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL ww_read_cycle got=%0d want=3", cyc); d_exp_q.delete(); end
    else begin
      exp_v = d_exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL ww_read_data got=%h want=%h", got, exp_v); end
    end
    data_op(1'b0, 1'b0, 16'hFFFF, 16'h0000, cyc, got);
    total++;
    if (cyc != 2) begin bad++; $display("FAIL wb_read_cycle got=%0d want=2", cyc); d_exp_q.delete(); end
    else begin
      exp_v = d_exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL wb_read_zext got=%h want=%h", got, exp_v); end
    end
  endtask

  task automatic test_flush();
    int fa0, cyc;
    logic [15:0] got;
    f_exp_q.delete();
    fa0 = f_acks;
    @(negedge clk);
    f_req = 1'b1; f_addr = 16'h0200;
    step();
    step();
    f_flush = 1'b1; f_req = 1'b0;
    step();
    f_flush = 1'b0;
    total++;
    if (f_ack !== 1'b0) begin bad++; $display("FAIL flush_no_ack got=%b want=0", f_ack); end
    step();
    total++;
    if ({busy, 32'(f_acks - fa0)} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL flush_idle busy=%b acks=%0d want 0 0", busy, f_acks - fa0);
    end
    fetch_op(16'h0200, cyc, got);
    total++;
    if (cyc != 3) begin bad++; $display("FAIL flush_refetch_cycle got=%0d want=3", cyc); f_exp_q.delete(); end
    else begin
      exp_v = f_exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL flush_refetch_data got=%h want=%h", got, exp_v); end
    end
    // A flush in IDLE masks that cycle's request
    @(negedge clk);
    f_req = 1'b1; f_flush = 1'b1; f_addr = 16'h0010;
    step();
    f_req = 1'b0; f_flush = 1'b0;
    total++;
    if ({busy, mem_en} !== 2'b00) begin bad++; $display("FAIL flush_idle_mask busy=%b en=%b want 0 0", busy, mem_en); end
  endtask

  task automatic test_reset_mid();
    int da0, cyc;
    logic [15:0] got;
    d_exp_q.delete();
    da0 = d_acks;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 1'b1; d_addr = 16'h0300; d_wdata = 16'h5566;
    step();
    step();
    total++;
    if ({mem_en, mem_we, mem_addr} !== {2'b11, 16'h0301}) begin
      bad++; $display("FAIL rstmid_hi en=%b we=%b addr=%h want 1 1 0301", mem_en, mem_we, mem_addr);
    end
    rst = 1'b1;
    d_req = 1'b0;
    #1;
    total++;
    if ({mem_en, mem_we} !== 2'b00) begin bad++; $display("FAIL rstmid_drop en=%b we=%b want 0 0", mem_en, mem_we); end
    step();
    step();
    rst = 1'b0;
    step();
    total++;
    if ({busy, 32'(d_acks - da0)} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL rstmid_after busy=%b acks=%0d want 0 0", busy, d_acks - da0);
    end
    data_op(1'b0, 1'b0, 16'h0005, 16'h0000, cyc, got);
    total++;
    if (cyc != 2) begin bad++; $display("FAIL rstmid_read_cycle got=%0d want=2", cyc); d_exp_q.delete(); end
    else begin
      exp_v = d_exp_q.pop_front();
      total++;
      if (got !== exp_v) begin bad++; $display("FAIL rstmid_read_data got=%h want=%h", got, exp_v); end
    end
  endtask

  initial begin
    last_d = 16'h0000;
    test_reset();
    test_fetch();
    test_contention();
    test_back_to_back();
    test_byte_write();
    test_word_wrap();
    test_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
